// File: rtl/cpu_memsys.sv
// CPU-side memory responder: word RAM plus an I/O page with GPIO, cycle counter,
// countdown timer and a console transmit FIFO. Reads have one cycle of latency.
module cpu_memsys #(
    parameter int unsigned RAM_AWIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_raddr_i,
    input  logic        mem_rd_i,
    output logic [15:0] mem_rdata_o,
    input  logic [15:0] mem_waddr_i,
    input  logic [15:0] mem_wdata_i,
    input  logic        mem_wr_i,
    output logic [15:0] gpio_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0] ram [0:(2**RAM_AWIDTH)-1];
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];

    logic [15:0] rdata_q, rdata_d, gpio_q, gpio_d, cycles_q, cycles_d, timer_q, timer_d;
    logic        expired_q, expired_d, ovf_q, ovf_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic                  rd_ram, wr_ram, wr_gpio, wr_timer, wr_status, wr_con;
    logic [RAM_AWIDTH-1:0] ridx, widx;
    logic                  fifo_full, fifo_empty, pop, push_ok;
    logic [15:0]           status, rd_val;

    // Top 16 words form the I/O page; everything below is RAM (upper bits alias).
    assign rd_ram    = mem_raddr_i[15:4] != 12'hFFF;
    assign wr_ram    = mem_wr_i && (mem_waddr_i[15:4] != 12'hFFF);
    assign wr_gpio   = mem_wr_i && (mem_waddr_i == 16'hFFF0);
    assign wr_timer  = mem_wr_i && (mem_waddr_i == 16'hFFF2);
    assign wr_status = mem_wr_i && (mem_waddr_i == 16'hFFF3);
    assign wr_con    = mem_wr_i && (mem_waddr_i == 16'hFFF4);
    assign ridx      = mem_raddr_i[RAM_AWIDTH-1:0];
    assign widx      = mem_waddr_i[RAM_AWIDTH-1:0];

    assign fifo_full  = count_q == CntW'(FIFO_DEPTH);
    assign fifo_empty = count_q == '0;
    assign pop        = !fifo_empty && con_ready_i;
    assign push_ok    = wr_con && (!fifo_full || pop);
    assign status     = {12'h000, ovf_q, fifo_empty, fifo_full, expired_q};

    assign mem_rdata_o = rdata_q;
    assign gpio_o      = gpio_q;
    assign con_valid_o = !fifo_empty;
    assign con_data_o  = fifo_empty ? 8'h00 : fifo_mem[rptr_q];

    // I/O reads see pre-edge state; RAM and GPIO forward a same-cycle write.
    always_comb begin
        rd_val = '0;
        if (rd_ram) begin
            rd_val = (wr_ram && (ridx == widx)) ? mem_wdata_i : ram[ridx];
        end else begin
            case (mem_raddr_i[3:0])
                4'h0:    rd_val = wr_gpio ? mem_wdata_i : gpio_q;
                4'h1:    rd_val = cycles_q;
                4'h2:    rd_val = timer_q;
                4'h3:    rd_val = status;
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        rdata_d   = mem_rd_i ? rd_val : rdata_q;
        cycles_d  = cycles_q + 16'd1;
        gpio_d    = wr_gpio ? mem_wdata_i : gpio_q;
        timer_d   = timer_q;
        expired_d = expired_q;
        ovf_d     = ovf_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;

        if (wr_timer) begin
            timer_d = mem_wdata_i;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
        // Clears are applied first so a same-cycle set wins.
        if (wr_status && mem_wdata_i[0]) expired_d = 1'b0;
        if (wr_status && mem_wdata_i[3]) ovf_d = 1'b0;
        if (!wr_timer && (timer_q == 16'd1)) expired_d = 1'b1;
        if (wr_con && !push_ok) ovf_d = 1'b1;

        if (push_ok) wptr_d = wptr_q + PtrW'(1);
        if (pop) rptr_d = rptr_q + PtrW'(1);
        if (push_ok && !pop) count_d = count_q + CntW'(1);
        else if (pop && !push_ok) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            gpio_q    <= '0;
            cycles_q  <= '0;
            timer_q   <= '0;
            expired_q <= 1'b0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            rdata_q   <= rdata_d;
            gpio_q    <= gpio_d;
            cycles_q  <= cycles_d;
            timer_q   <= timer_d;
            expired_q <= expired_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[widx] <= mem_wdata_i;
        if (push_ok) fifo_mem[wptr_q] <= mem_wdata_i[7:0];
    end

endmodule

// File: tb/tb_cpu_memsys.sv
// Randomized scoreboard bench for cpu_memsys against a queue/array reference model.
module tb_cpu_memsys;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_raddr_i = '0, mem_waddr_i = '0, mem_wdata_i = '0;
    logic        mem_rd_i = 1'b0, mem_wr_i = 1'b0, con_ready_i = 1'b0;
    logic [15:0] mem_rdata_o, gpio_o;
    logic [7:0]  con_data_o;
    logic        con_valid_o;

    always #5 clk = ~clk;

    cpu_memsys #(.RAM_AWIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_raddr_i(mem_raddr_i), .mem_rd_i(mem_rd_i), .mem_rdata_o(mem_rdata_o),
        .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i), .mem_wr_i(mem_wr_i),
        .gpio_o(gpio_o), .con_data_o(con_data_o), .con_valid_o(con_valid_o),
        .con_ready_i(con_ready_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (post-edge view of the design).
    logic [15:0] m_ram [int];
    logic [15:0] m_gpio, m_cycles, m_timer;
    logic        m_exp, m_ovf;
    logic [7:0]  m_fifo [$];
    logic [15:0] exp_q [$];
    logic [15:0] ram_pool [$];

    function automatic void check(string name, logic [15:0] act, logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic bit is_io(input logic [15:0] a);
        return a >= 16'hFFF0;
    endfunction

    function automatic int idx(input logic [15:0] a);
        return int'(a) % (1 << AW);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] st;
        if (!is_io(a)) return m_ram.exists(idx(a)) ? m_ram[idx(a)] : 16'h0000;
        st = 16'h0000;
        st[0] = m_exp;
        st[1] = m_fifo.size() == DEPTH;
        st[2] = m_fifo.size() == 0;
        st[3] = m_ovf;
        case (a)
            16'hFFF0: return m_gpio;
            16'hFFF1: return m_cycles;
            16'hFFF2: return m_timer;
            16'hFFF3: return st;
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic void model_reset();
        m_gpio = '0; m_cycles = '0; m_timer = '0; m_exp = 1'b0; m_ovf = 1'b0;
        m_fifo.delete();
        exp_q.delete();
    endfunction

    // Called at a negedge: drive one cycle, predict its effect, wait for the next negedge.
    task automatic step(input logic rd, input logic [15:0] ra, input logic wr,
                        input logic [15:0] wa, input logic [15:0] wd, input logic rdy);
        logic [15:0] rv;
        bit pop;
        int pre;
        mem_rd_i = rd; mem_raddr_i = ra; mem_wr_i = wr; mem_waddr_i = wa;
        mem_wdata_i = wd; con_ready_i = rdy;
        pre = m_fifo.size();
        pop = (pre != 0) && rdy;
        if (rd) begin
            rv = model_read(ra);
            if (wr && !is_io(wa) && !is_io(ra) && idx(wa) == idx(ra)) rv = wd;
            if (wr && wa == 16'hFFF0 && ra == 16'hFFF0) rv = wd;
            exp_q.push_back(rv);
        end
        if (wr && wa == 16'hFFF3) begin
            if (wd[0]) m_exp = 1'b0;
            if (wd[3]) m_ovf = 1'b0;
        end
        if (m_timer == 16'd1 && !(wr && wa == 16'hFFF2)) m_exp = 1'b1;
        if (wr && wa == 16'hFFF2) m_timer = wd;
        else if (m_timer != 16'd0) m_timer = m_timer - 16'd1;
        if (pop) void'(m_fifo.pop_front());
        if (wr && wa == 16'hFFF4) begin
            if (pre < DEPTH || pop) m_fifo.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && wa == 16'hFFF0) m_gpio = wd;
        if (wr && !is_io(wa)) m_ram[idx(wa)] = wd;
        m_cycles = m_cycles + 16'd1;
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 9) < 6) return ram_pool[$urandom_range(0, ram_pool.size() - 1)];
        return 16'hFFF0 + 16'($urandom_range(0, 15));
    endfunction

    // Monitor: pops the scoreboard on every accepted read and checks held outputs.
    logic [15:0] hold = '0;
    logic        rd_s;
    initial begin
        forever begin
            @(posedge clk);
            rd_s = mem_rd_i;
            #1;
            if (reset) begin
                hold = '0;
            end else begin
                if (rd_s) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rdata: read with empty scoreboard at %0t", $time);
                    end else begin
                        hold = exp_q.pop_front();
                    end
                end
                check("rdata", mem_rdata_o, hold);
                check("gpio", gpio_o, m_gpio);
                check("con_valid", {15'h0, con_valid_o}, {15'h0, m_fifo.size() != 0});
                check("con_data", {8'h0, con_data_o},
                      (m_fifo.size() != 0) ? {8'h0, m_fifo[0]} : 16'h0000);
            end
        end
    end

    initial begin
        logic [15:0] ra, wa, wd, a;
        int bound;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // RAM write, read back, alias read
        step(0, 0, 1, 16'h0123, 16'hBEEF, 0);
        step(1, 16'h0123, 0, 0, 0, 0);
        step(1, 16'h1123, 0, 0, 0, 0);
        // Same-cycle write/read forwarding on RAM and GPIO, then hold
        step(1, 16'h0040, 1, 16'h0040, 16'h5A5A, 0);
        step(1, 16'hFFF0, 1, 16'hFFF0, 16'h5A5A, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Timer countdown, sticky expire, clear, rewrite at count 1
        step(0, 0, 1, 16'hFFF2, 16'd3, 0);
        repeat (5) step(1, 16'hFFF2, 0, 0, 0, 0);
        step(1, 16'hFFF3, 0, 0, 0, 0);
        step(0, 0, 1, 16'hFFF3, 16'h0001, 0);
        step(1, 16'hFFF3, 0, 0, 0, 0);
        step(0, 0, 1, 16'hFFF2, 16'd3, 0);
        step(1, 16'hFFF2, 0, 0, 0, 0);
        step(1, 16'hFFF2, 0, 0, 0, 0);
        step(1, 16'hFFF2, 1, 16'hFFF2, 16'd5, 0);
        step(1, 16'hFFF2, 0, 0, 0, 0);
        step(1, 16'hFFF3, 0, 0, 0, 0);
        step(0, 0, 1, 16'hFFF2, 16'd0, 0);

        // FIFO fill with overflow, push+pop while full, drain
        for (int b = 8'h41; b <= 8'h45; b++) step(0, 0, 1, 16'hFFF4, 16'(b), 0);
        step(1, 16'hFFF3, 0, 0, 0, 0);
        step(0, 0, 1, 16'hFFF4, 16'h0046, 1);
        step(1, 16'hFFF3, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0, 1);
        step(1, 16'hFFF3, 1, 16'hFFF3, 16'h0008, 0);
        step(1, 16'hFFF3, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a pending read
        step(0, 0, 1, 16'hFFF0, 16'h00FF, 0);
        step(0, 0, 1, 16'hFFF4, 16'h0077, 0);
        bound = 0;
        while (m_cycles != 16'h0100 && bound < 1000) begin
            step(0, 0, 0, 0, 0, 0);
            bound++;
        end
        mem_rd_i = 1'b1; mem_raddr_i = 16'hFFF1;
        #2 reset = 1'b1;
        #1;
        check("reset_rdata", mem_rdata_o, 16'h0000);
        check("reset_gpio", gpio_o, 16'h0000);
        check("reset_con_valid", {15'h0, con_valid_o}, 16'h0000);
        check("reset_con_data", {8'h0, con_data_o}, 16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 16'hFFF1, 0, 0, 0, 0);
        step(1, 16'hFFF1, 0, 0, 0, 0);
        step(1, 16'h0123, 0, 0, 0, 0);
        step(1, 16'h0040, 0, 0, 0, 0);

        // Randomized traffic over a pool of initialised RAM addresses and the I/O page
        ram_pool.push_back(16'h0123);
        ram_pool.push_back(16'h1040);
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom_range(0, (1 << AW) - 1)) | 16'($urandom_range(0, 14) << AW);
            step(0, 0, 1, a, 16'($urandom), 0);
            ram_pool.push_back(a);
        end
        for (int n = 0; n < 1500; n++) begin
            ra = pick_addr();
            wa = ($urandom_range(0, 7) == 0) ? ra : pick_addr();
            wd = 16'($urandom);
            if (wa == 16'hFFF2) wd = 16'($urandom_range(0, 6));
            step($urandom_range(0, 3) != 0, ra, $urandom_range(0, 1) == 1, wa, wd,
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_memsys.md
# cpu_memsys

CPU-side memory responder: the slave end of the CPU's split read/write memory bus. It serves instruction fetches, loads and stores from an on-chip word RAM, and decodes a small I/O page at the top of the address space. The page holds a GPIO register, a free-running cycle counter, a countdown timer and a console transmit FIFO. It sits between the CPU core and the board pins; reads have a fixed single-cycle latency, which is what the CPU fetch/load logic expects.

## Interface
- RAM_AWIDTH, 12: RAM holds 2^RAM_AWIDTH 16-bit words; range 8..15.
- FIFO_DEPTH, 4: console FIFO entries; power of two, ≥2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_raddr_i  in  16  read word address.
- mem_rd_i  in  1  read request; sampled every edge.
- mem_rdata_o  out  16  read data, registered.
- mem_waddr_i  in  16  write word address.
- mem_wdata_i  in  16  write data.
- mem_wr_i  in  1  write strobe; the write commits on this edge.
- gpio_o  out  16  GPIO output register.
- con_data_o  out  8  FIFO head byte.
- con_valid_o  out  1  FIFO non-empty.
- con_ready_i  in  1  sink accepts the head byte when it is high while con_valid_o is high.

## Operation
- Memory map (word addresses):
  - 0x0000–0xFFEF: RAM, indexed by addr[RAM_AWIDTH-1:0]; upper bits alias.
  - 0xFFF0 GPIO: read/write.
  - 0xFFF1 CYCLES: read-only; writes ignored.
  - 0xFFF2 TIMER: a write loads the value; a read returns the current count.
  - 0xFFF3 STATUS: bit0 timer expired (sticky), bit1 FIFO full, bit2 FIFO empty, bit3 FIFO overflow (sticky). A write clears bit0 and/or bit3 where the wdata bit is 1; other bits read 0.
  - 0xFFF4 CONSOLE: a write pushes wdata[7:0]; a read returns 0.
  - 0xFFF5–0xFFFF: read 0; writes ignored.
- RAM: single write port, single read port, no reset of contents.
- Same-cycle write and read to the same RAM or GPIO address: read returns mem_wdata_i (write-first forwarding).
- I/O register reads return the value held during the request cycle, before that edge's update.
- CYCLES: increments every clock; wraps 0xFFFF→0x0000.
- TIMER:
  - If nonzero, decrements by 1 per clock.
  - The 1→0 transition sets expired.
  - A CPU write in the same cycle overrides the decrement.
  - Writing 0 stops the timer without setting expired.
  - Set and clear of expired in the same cycle: set wins.
- FIFO:
  - Push is accepted if not full, or if a pop occurs the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pop when con_valid_o && con_ready_i.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
  - con_data_o and con_valid_o are driven from registers/storage, with no combinational path from con_ready_i.

## Timing
- Read: address sampled at edge N with mem_rd_i=1; mem_rdata_o is valid from after edge N until edge N+1. Back-to-back reads are sustained every cycle.
- mem_rd_i=0: mem_rdata_o holds its previous value.
- Write: state updates at the edge where mem_wr_i=1. A read issued the following cycle sees the new value.
- FIFO latency: a byte written at edge N appears on con_data_o/con_valid_o after edge N. A pop at edge N exposes the next entry after N.
- Reset values, all asserted asynchronously:
  - mem_rdata_o=0, gpio_o=0, CYCLES=0, TIMER=0, STATUS sticky bits=0.
  - FIFO empty, so con_valid_o=0 and con_data_o=0.
- RAM contents are retained across reset.
- Reset during a pending read: the read is discarded and mem_rdata_o=0 after reset releases.
- Reset release: CYCLES counts 1 at the first rising edge after deassertion.

## Test plan
- Write RAM[0x0123]=0xBEEF, read 0x0123 next cycle → mem_rdata_o=0xBEEF one cycle after the request. Read 0x1123 (alias, RAM_AWIDTH=12) → 0xBEEF.
- Same-cycle write 0x5A5A to 0x0040 with read of 0x0040 → 0x5A5A. Same test on GPIO 0xFFF0 → gpio_o=0x5A5A and read returns 0x5A5A.
- Write TIMER=3 → counts 3,2,1,0. STATUS bit0=1 after 3 edges and stays 1 until a write of 0x0001 to 0xFFF3. Rewrite at count 1 with 5 → no expire; count restarts at 5.
- With con_ready_i=0, push 5 bytes 0x41..0x45 → FIFO holds 0x41..0x44, STATUS=0x000A (full, overflow). Raise con_ready_i → bytes appear in order, one per cycle, then con_valid_o=0 and STATUS bit2=1.
- FIFO full, push and pop in the same cycle → both accepted, occupancy stays FIFO_DEPTH, overflow unchanged.
- Assert reset mid-read with CYCLES=0x0100, gpio_o=0x00FF → all outputs 0 immediately. After release, read 0xFFF1 on the first cycle → 0x0000 or 0x0001 according to the request edge; RAM data written before reset is intact.
